hazard_scoreboard_unit: RTL



---
 rtl/hazard_pkg.sv | 20 ++
 rtl/reg_scoreboard.sv | 65 ++++++
 rtl/hazard_scoreboard_unit.sv | 105 ++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  // E-stage operand source select.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10,
    FWD_LOP = 2'b11
  } fwd_sel_t;

  // Bit positions in the stall-cause vector.
  localparam int unsigned STALL_LDR    = 0;
  localparam int unsigned STALL_LOPE   = 1;
  localparam int unsigned STALL_SB     = 2;
  localparam int unsigned STALL_STRUCT = 3;
  localparam int unsigned STALL_NOFWD  = 4;
  localparam int unsigned STALL_N      = 5;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard for long-latency ops: busy bits, outstanding count, sticky error.
module reg_scoreboard #(
  parameter int unsigned RA_W    = 4,
  parameter int unsigned MAX_OUT = 2,
  localparam int unsigned NREG   = 1 << RA_W,
  localparam int unsigned CNT_W  = $clog2(MAX_OUT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_issue,
  input  logic [RA_W-1:0]  i_issue_wa,
  input  logic             i_done,
  input  logic [RA_W-1:0]  i_done_wa,
  output logic [NREG-1:0]  o_busy,
  output logic [CNT_W-1:0] o_count,
  output logic             o_err
);

  logic [NREG-1:0]  r_busy;
  logic [CNT_W-1:0] r_count;
  logic             r_err;

  logic [NREG-1:0]  w_busy_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_err_nxt;
  logic             w_done_ok;
  logic             w_dec;
  logic             w_at_max;

  // Next-state: clear then set so a same-register set wins; a completion paired
  // with any issue on the same register leaves the count where it was.
  always_comb begin
    w_busy_nxt  = r_busy;
    w_count_nxt = r_count;
    w_done_ok   = i_done & r_busy[i_done_wa];
    w_dec       = w_done_ok | (i_issue & i_done & (i_issue_wa == i_done_wa));
    w_at_max    = (r_count == CNT_W'(MAX_OUT));
    if (i_done)  w_busy_nxt[i_done_wa]  = 1'b0;
    if (i_issue) w_busy_nxt[i_issue_wa] = 1'b1;
    if (i_issue && !w_dec) begin
      if (!w_at_max) w_count_nxt = r_count + CNT_W'(1);
    end else if (!i_issue && w_dec && (r_count != '0)) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
    w_err_nxt = r_err | (i_done & ~r_busy[i_done_wa]) | (i_issue & w_at_max);
  end

  // Scoreboard state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_busy  <= w_busy_nxt;
      r_count <= w_count_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign o_busy  = r_busy;
  assign o_count = r_count;
  assign o_err   = r_err;

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Hazard controller for the F/D/E/M/W pipeline: forwarding, stall/flush and long-op scoreboard.
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned RA_W    = 4,
  parameter int unsigned MAX_OUT = 2,
  parameter bit          FWD_EN  = 1'b1,
  localparam int unsigned NREG   = 1 << RA_W,
  localparam int unsigned CNT_W  = $clog2(MAX_OUT + 1)
) (
  input  logic             CLK_50,
  input  logic             reset,
  input  logic [RA_W-1:0]  ra1d,
  input  logic [RA_W-1:0]  ra2d,
  input  logic [RA_W-1:0]  wa3d,
  input  logic             regwrite_d,
  input  logic             lop_d,
  input  logic [RA_W-1:0]  ra1e,
  input  logic [RA_W-1:0]  ra2e,
  input  logic [RA_W-1:0]  wa3e,
  input  logic             regwrite_e,
  input  logic             memtoreg_e,
  input  logic             lop_e,
  input  logic [RA_W-1:0]  wa3m,
  input  logic [RA_W-1:0]  wa3w,
  input  logic             regwrite_m,
  input  logic             regwrite_w,
  input  logic             pcs_d,
  input  logic             pcs_e,
  input  logic             pcs_m,
  input  logic             pcsrc_w,
  input  logic             branch_taken_e,
  input  logic             lop_done,
  input  logic [RA_W-1:0]  lop_wa,
  output fwd_sel_t         forward_ae,
  output fwd_sel_t         forward_be,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_d,
  output logic             flush_e,
  output logic [NREG-1:0]  sb_busy,
  output logic [CNT_W-1:0] sb_count,
  output logic             sb_err
);

  logic [STALL_N-1:0] w_cause;
  logic               w_hz;
  logic               w_pc_pend;

  // Priority select for one E-stage source: long unit, then M, then W.
  function automatic fwd_sel_t fwd_for(input logic [RA_W-1:0] src);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (lop_done && (lop_wa == src))          sel = FWD_LOP;
    else if (regwrite_m && (wa3m == src))     sel = FWD_M;
    else if (regwrite_w && (wa3w == src))     sel = FWD_W;
    return sel;
  endfunction

  reg_scoreboard #(
    .RA_W    (RA_W),
    .MAX_OUT (MAX_OUT)
  ) u_sb (
    .clk        (CLK_50),
    .rst        (reset),
    .i_issue    (lop_e & regwrite_e),
    .i_issue_wa (wa3e),
    .i_done     (lop_done),
    .i_done_wa  (lop_wa),
    .o_busy     (sb_busy),
    .o_count    (sb_count),
    .o_err      (sb_err)
  );

  // Operand forwarding selects; register file only when forwarding is disabled.
  always_comb begin
    forward_ae = FWD_RF;
    forward_be = FWD_RF;
    if (FWD_EN) begin
      forward_ae = fwd_for(ra1e);
      forward_be = fwd_for(ra2e);
    end
  end

  // Stall causes, combined into the pipeline stall/flush controls.
  always_comb begin
    w_cause = '0;
    w_cause[STALL_LDR]    = memtoreg_e & regwrite_e & ((wa3e == ra1d) | (wa3e == ra2d));
    w_cause[STALL_LOPE]   = lop_e & ((wa3e == ra1d) | (wa3e == ra2d) |
                                     (regwrite_d & (wa3e == wa3d)));
    w_cause[STALL_SB]     = sb_busy[ra1d] | sb_busy[ra2d] | (regwrite_d & sb_busy[wa3d]);
    w_cause[STALL_STRUCT] = lop_d & ((32'(sb_count) + 32'(lop_e)) >= MAX_OUT);
    if (!FWD_EN) begin
      w_cause[STALL_NOFWD] = (regwrite_e & ((wa3e == ra1d) | (wa3e == ra2d))) |
                             (regwrite_m & ((wa3m == ra1d) | (wa3m == ra2d)));
    end
    w_hz      = |w_cause;
    w_pc_pend = pcs_d | pcs_e | pcs_m;
    stall_d   = w_hz;
    stall_f   = w_hz | w_pc_pend;
    flush_e   = w_hz | branch_taken_e;
    flush_d   = w_pc_pend | pcsrc_w | branch_taken_e;
  end

endmodule
